// File: rtl/chip_check_sequencer.sv
// Purpose: runs one chip test: latch selection, grant pin bus, pulse Start, await Done with watchdog, hold result.
// Latency: Grant 1 cycle after Run edge, Start 1 cycle later; result 1 cycle after Done rise or TIMEOUT WAIT cycles.
// Backpressure: none; Run edges outside IDLE/RESULT and all non-selected tester inputs are ignored.
//
// Ports:
//   Clk, Reset      - clock and synchronous active-high reset
//   Run             - operator button level; only rising edges act
//   SW              - chip selection switches (1..N_CHIPS selects tester SW-1)
//   Done, Rslt      - per-tester done level and pass/fail
//   Start, Grant    - one-hot start pulse and pin-bus ownership for the selected tester
//   LD_SW           - display shows live switches (IDLE)
//   DISP_RSLT       - display shows result (RESULT)
//   Busy            - check in progress
//   RSLT            - latched pass/fail
//   Timeout_Flag    - last check ended by the watchdog
//   Bad_Sel         - last selection was out of range
//   Sel_Q           - latched selection
module chip_check_sequencer #(
   parameter int N_CHIPS = 4,
   parameter int TIMEOUT = 1024,
   parameter int SEL_W   = 10
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Run,
   input  logic [SEL_W-1:0]   SW,
   input  logic [N_CHIPS-1:0] Done,
   input  logic [N_CHIPS-1:0] Rslt,
   output logic [N_CHIPS-1:0] Start,
   output logic [N_CHIPS-1:0] Grant,
   output logic               LD_SW,
   output logic               DISP_RSLT,
   output logic               Busy,
   output logic               RSLT,
   output logic               Timeout_Flag,
   output logic               Bad_Sel,
   output logic [SEL_W-1:0]   Sel_Q
);

   localparam int             WD_W    = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_START,
      S_WAIT,
      S_RESULT
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               run_q;
   logic [N_CHIPS-1:0] done_q;
   logic [N_CHIPS-1:0] sel_oh;
   logic [WD_W-1:0]    wdog;
   logic               run_edge;
   logic               sel_valid;
   logic               done_rise;
   logic               rslt_sel;
   logic               wdog_last;

   // run_q resets high so a button held through reset is not seen as an edge.
   assign run_edge  = Run & ~run_q;
   assign sel_valid = (SW != '0) && (SW <= SEL_W'(N_CHIPS));

   // One-hot of the latched selection; all zero for an out-of-range Sel_Q.
   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < N_CHIPS; i++) begin
         sel_oh[i] = (Sel_Q == SEL_W'(i + 1));
      end
   end

   // Only a low-to-high transition of the selected tester's Done counts, so a
   // Done already high when Start fires must fall and rise again.
   assign done_rise = |(Done & sel_oh & ~done_q);
   assign rslt_sel  = |(Rslt & sel_oh);
   assign wdog_last = (wdog == WD_LAST);

   always_comb begin
      state_nxt = state;
      Grant     = '0;
      Start     = '0;
      LD_SW     = 1'b0;
      DISP_RSLT = 1'b0;
      Busy      = 1'b0;
      case (state)
         S_IDLE: begin
            LD_SW = 1'b1;
            if (run_edge) begin
               state_nxt = sel_valid ? S_GRANT : S_RESULT;
            end
         end
         S_GRANT: begin
            // One settle cycle on the pin bus before the tester is started.
            Grant     = sel_oh;
            Busy      = 1'b1;
            state_nxt = S_START;
         end
         S_START: begin
            Grant     = sel_oh;
            Start     = sel_oh;
            Busy      = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            Grant = sel_oh;
            Busy  = 1'b1;
            if (done_rise || wdog_last) begin
               state_nxt = S_RESULT;
            end
         end
         S_RESULT: begin
            DISP_RSLT = 1'b1;
            if (run_edge) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= S_IDLE;
         run_q        <= 1'b1;
         Sel_Q        <= '0;
         RSLT         <= 1'b0;
         Timeout_Flag <= 1'b0;
         Bad_Sel      <= 1'b0;
         wdog         <= '0;
         done_q       <= '0;
      end else begin
         state <= state_nxt;
         run_q <= Run;
         case (state)
            S_IDLE: begin
               if (run_edge) begin
                  Sel_Q        <= SW;
                  RSLT         <= 1'b0;
                  Timeout_Flag <= 1'b0;
                  Bad_Sel      <= ~sel_valid;
               end
            end
            S_START: begin
               done_q <= (done_q & ~sel_oh) | (Done & sel_oh);
               wdog   <= '0;
            end
            S_WAIT: begin
               done_q <= (done_q & ~sel_oh) | (Done & sel_oh);
               // Done has priority over a watchdog expiring in the same cycle.
               if (done_rise) begin
                  RSLT <= rslt_sel;
               end else if (wdog_last) begin
                  RSLT         <= 1'b0;
                  Timeout_Flag <= 1'b1;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chip_check_sequencer.sv
// Purpose: randomized self-checking bench for chip_check_sequencer against a transaction-level timing model.
// Latency: expectations are derived per check from Run edge time, Done rise time and the watchdog length.
// Backpressure: none; stray Run pulses, SW changes and foreign Done/Rslt are injected and must be ignored.
module tb_chip_check_sequencer;
   localparam int N    = 4;
   localparam int T    = 16;
   localparam int SW_W = 10;

   logic            Clk = 1'b0;
   logic            Reset;
   logic            Run;
   logic [SW_W-1:0] SW;
   logic [N-1:0]    Done;
   logic [N-1:0]    Rslt;
   logic [N-1:0]    Start;
   logic [N-1:0]    Grant;
   logic            LD_SW;
   logic            DISP_RSLT;
   logic            Busy;
   logic            RSLT;
   logic            Timeout_Flag;
   logic            Bad_Sel;
   logic [SW_W-1:0] Sel_Q;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   chip_check_sequencer #(
      .N_CHIPS (N),
      .TIMEOUT (T),
      .SEL_W   (SW_W)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Run          (Run),
      .SW           (SW),
      .Done         (Done),
      .Rslt         (Rslt),
      .Start        (Start),
      .Grant        (Grant),
      .LD_SW        (LD_SW),
      .DISP_RSLT    (DISP_RSLT),
      .Busy         (Busy),
      .RSLT         (RSLT),
      .Timeout_Flag (Timeout_Flag),
      .Bad_Sel      (Bad_Sel),
      .Sel_Q        (Sel_Q)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // Scramble the inputs of every tester except idx (idx < 0 scrambles all).
   task automatic drive_others(input int idx);
      for (int i = 0; i < N; i++) begin
         if (i != idx) begin
            Done[i] = 1'($urandom_range(0, 1));
            Rslt[i] = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_ld_sw"}, 32'(LD_SW), 32'd1);
      check_val({tag, "_grant"}, 32'(Grant), 32'd0);
      check_val({tag, "_start"}, 32'(Start), 32'd0);
      check_val({tag, "_busy"}, 32'(Busy), 32'd0);
      check_val({tag, "_disp"}, 32'(DISP_RSLT), 32'd0);
      check_val({tag, "_rslt"}, 32'(RSLT), 32'd0);
      check_val({tag, "_tflag"}, 32'(Timeout_Flag), 32'd0);
      check_val({tag, "_badsel"}, 32'(Bad_Sel), 32'd0);
      check_val({tag, "_selq"}, 32'(Sel_Q), 32'd0);
   endtask

   // One full check from IDLE back to IDLE.
   // done_at: WAIT cycle (1-based) in which the selected Done is first high; 0 = never.
   // pre_high: selected Done already high at Start, dropping before WAIT cycle 3.
   // extra_run: a stray Run pulse during WAIT.
   task automatic do_check(input logic [SW_W-1:0] sw, input int done_at, input bit r,
                           input bit pre_high, input bit extra_run);
      bit          valid;
      bit          hit;
      int          idx;
      int          fin;
      int          run_len;
      int          w;
      bit          busy_e;
      logic [N-1:0] oh;
      bit          exp_r;
      bit          exp_to;

      valid   = (sw >= 1) && (sw <= N);
      run_len = $urandom_range(1, 3);
      SW      = sw;
      Run     = 1'b1;
      if (valid) begin
         idx       = int'(sw) - 1;
         oh        = N'(1) << idx;
         hit       = (done_at >= 1) && (done_at <= T);
         fin       = hit ? done_at : T;
         exp_r     = hit ? r : 1'b0;
         exp_to    = !hit;
         Done[idx] = pre_high;
         Rslt[idx] = 1'($urandom_range(0, 1));
         for (int c = 0; c <= 2 + fin; c++) begin
            tick();
            busy_e = (c <= 1 + fin);
            check_val("grant", 32'(Grant), busy_e ? 32'(oh) : 32'd0);
            check_val("start", 32'(Start), (c == 1) ? 32'(oh) : 32'd0);
            check_val("busy", 32'(Busy), 32'(busy_e));
            check_val("disp", 32'(DISP_RSLT), 32'(!busy_e));
            check_val("ld_sw", 32'(LD_SW), 32'd0);
            check_val("sel_q", 32'(Sel_Q), 32'(sw));
            check_val("badsel", 32'(Bad_Sel), 32'd0);
            check_val("rslt", 32'(RSLT), busy_e ? 32'd0 : 32'(exp_r));
            check_val("tflag", 32'(Timeout_Flag), busy_e ? 32'd0 : 32'(exp_to));
            // Inputs for the next edge, which is WAIT cycle w.
            if (c >= run_len - 1) Run = 1'b0;
            if (extra_run && c == 3) Run = 1'b1;
            w = c - 1;
            Done[idx] = ((done_at >= 1) && (w >= done_at)) || (pre_high && (w <= 2));
            Rslt[idx] = ((done_at >= 1) && (w >= done_at)) ? r : 1'($urandom_range(0, 1));
            SW = SW_W'($urandom_range(0, 1023));
            drive_others(idx);
         end
      end else begin
         exp_r  = 1'b0;
         exp_to = 1'b0;
         for (int c = 0; c < 3; c++) begin
            tick();
            check_val("bad_disp", 32'(DISP_RSLT), 32'd1);
            check_val("bad_grant", 32'(Grant), 32'd0);
            check_val("bad_start", 32'(Start), 32'd0);
            check_val("bad_busy", 32'(Busy), 32'd0);
            check_val("bad_flag", 32'(Bad_Sel), 32'd1);
            check_val("bad_rslt", 32'(RSLT), 32'd0);
            check_val("bad_selq", 32'(Sel_Q), 32'(sw));
            Run = 1'b0;
            SW  = SW_W'($urandom_range(0, 1023));
            drive_others(-1);
         end
      end
      // Back to IDLE; latched result must survive until the next check starts.
      Done = '0;
      Run  = 1'b1;
      tick();
      check_val("ret_ld_sw", 32'(LD_SW), 32'd1);
      check_val("ret_disp", 32'(DISP_RSLT), 32'd0);
      check_val("ret_grant", 32'(Grant), 32'd0);
      check_val("ret_rslt", 32'(RSLT), 32'(exp_r));
      check_val("ret_tflag", 32'(Timeout_Flag), 32'(exp_to));
      check_val("ret_badsel", 32'(Bad_Sel), 32'(!valid));
      check_val("ret_selq", 32'(Sel_Q), 32'(sw));
      Run = 1'b0;
      tick();
      check_val("idle_busy", 32'(Busy), 32'd0);
   endtask

   initial begin
      Reset = 1'b1;
      Run   = 1'b1;
      SW    = '0;
      Done  = '0;
      Rslt  = '0;
      repeat (3) tick();
      check_reset_vals("rst");

      // Release reset with Run still held: no edge may be seen.
      Reset = 1'b0;
      SW    = SW_W'(3);
      tick();
      tick();
      check_reset_vals("held_run");
      Run = 1'b0;
      tick();

      do_check(SW_W'(1), 5, 1'b1, 1'b0, 1'b0);
      do_check(SW_W'(2), 7, 1'b0, 1'b0, 1'b1);
      do_check(SW_W'(3), 0, 1'b1, 1'b0, 1'b0);
      do_check(SW_W'(3), T, 1'b1, 1'b0, 1'b0);
      do_check(SW_W'(3), T, 1'b0, 1'b0, 1'b1);
      do_check(SW_W'(0), 0, 1'b0, 1'b0, 1'b0);
      do_check(SW_W'(7), 0, 1'b0, 1'b0, 1'b0);
      do_check(SW_W'(1), 8, 1'b1, 1'b1, 1'b0);
      do_check(SW_W'(4), 1, 1'b1, 1'b0, 1'b0);

      // Reset during the third WAIT cycle.
      SW   = SW_W'(2);
      Done = '0;
      Run  = 1'b1;
      for (int c = 0; c <= 4; c++) begin
         tick();
         Run = 1'b0;
      end
      check_val("pre_rst_grant", 32'(Grant), 32'h2);
      Reset = 1'b1;
      tick();
      check_reset_vals("mid_wait_rst");
      Reset = 1'b0;
      tick();
      do_check(SW_W'(2), 3, 1'b1, 1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         int          da;
         bit          pre;
         bit          ext;
         logic [SW_W-1:0] s;
         s   = SW_W'($urandom_range(0, 6));
         da  = $urandom_range(0, T + 2);
         pre = (da == 0 || da >= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
         ext = (da == 0 || da >= 5) ? 1'($urandom_range(0, 1)) : 1'b0;
         do_check(s, da, 1'($urandom_range(0, 1)), pre, ext);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
